// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential non-restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/cas_row.sv
// Controlled add/subtract row: ctrl=1 gives a-b, ctrl=0 gives a+b, modulo 2^N.
module cas_row #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  output logic [N-1:0] s
);

  // Subtraction as a + ~b + 1: invert b with ctrl and feed ctrl in as carry.
  logic [N-1:0] b_x;
  logic [N-1:0] cin;

  assign b_x = b ^ {N{ctrl}};
  assign cin = {{(N-1){1'b0}}, ctrl};
  assign s   = a + b_x + cin;

endmodule

// File: rtl/nr_seq_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per cycle, valid/ready on both sides.
module nr_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   d;
  logic [WIDTH-1:0] a;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   row_a;
  logic [WIDTH:0]   row_s;
  logic             row_ctrl;

  // One shared row: RUN feeds the shifted {P,A}; FIX adds D back to a negative P.
  always_comb begin
    row_a    = {p[WIDTH-1:0], a[WIDTH-1]};
    row_ctrl = ~p[WIDTH];
    if (state == FIX) begin
      row_a    = p;
      row_ctrl = 1'b0;
    end
  end

  cas_row #(.N(WIDTH + 1)) u_row (
    .a    (row_a),
    .b    (d),
    .ctrl (row_ctrl),
    .s    (row_s)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      d           <= '0;
      a           <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              d     <= {1'b0, divisor};
              p     <= '0;
              a     <= dividend;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          p   <= row_s;
          a   <= {a[WIDTH-2:0], ~row_s[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient    <= a;
          remainder   <= p[WIDTH] ? row_s[WIDTH-1:0] : p[WIDTH-1:0];
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_seq_divider.sv
// Directed bench for nr_seq_divider: arithmetic model, latency, backpressure and reset abort.
module tb_nr_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  nr_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Expected result of the operation currently in flight, from plain integer arithmetic.
  logic [W-1:0] exp_q = '0;
  logic [W-1:0] exp_r = '0;
  logic         exp_z = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_model(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == '0) begin
      exp_q = '1;
      exp_r = n;
      exp_z = 1'b1;
    end else begin
      exp_q = n / d;
      exp_r = n % d;
      exp_z = 1'b0;
    end
  endtask

  // Every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("model quotient", 32'(quotient), 32'(exp_q));
      chk("model remainder", 32'(remainder), 32'(exp_r));
      chk("model div_by_zero", 32'(div_by_zero), 32'(exp_z));
      chk("in_ready low with result", 32'(in_ready), 32'd0);
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready wait", 32'(in_ready), 32'd1);
  endtask

  // Issue one division, check latency and literal results, optionally stall the sink.
  task automatic run(input logic [W-1:0] n, input logic [W-1:0] d,
                     input logic [W-1:0] q_lit, input logic [W-1:0] r_lit,
                     input logic z_lit, input int hold);
    int lat = 0;
    logic [W-1:0] q_hold, r_hold;
    wait_ready();
    set_model(n, d);
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency edges after accept", 32'(lat), (d == '0) ? 32'd0 : 32'(W + 1));
    chk("quotient literal", 32'(quotient), 32'(q_lit));
    chk("remainder literal", 32'(remainder), 32'(r_lit));
    chk("div_by_zero literal", 32'(div_by_zero), 32'(z_lit));
    q_hold = quotient;
    r_hold = remainder;
    for (int i = 0; i < hold; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom_range(1, 200));
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("held out_valid", 32'(out_valid), 32'd1);
      chk("held quotient", 32'(quotient), 32'(q_hold));
      chk("held remainder", 32'(remainder), 32'(r_hold));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid drop after handshake", 32'(out_valid), 32'd0);
    chk("in_ready after handshake", 32'(in_ready), 32'd1);
    chk("quotient kept after drain", 32'(quotient), 32'(q_hold));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run(16'd100,   16'd7,      16'd14,    16'd2,      1'b0, 0);
    run(16'd3,     16'd10,     16'd0,     16'd3,      1'b0, 0);
    run(16'hFFFF,  16'd1,      16'hFFFF,  16'd0,      1'b0, 0);
    run(16'hFFFF,  16'hFFFF,   16'd1,     16'd0,      1'b0, 0);
    run(16'd5,     16'd0,      16'hFFFF,  16'd5,      1'b1, 0);
    run(16'd100,   16'd7,      16'd14,    16'd2,      1'b0, 10);
    run(16'd1000,  16'd33,     16'd30,    16'd10,     1'b0, 0);
    run(16'hFFFF,  16'h8000,   16'd1,     16'h7FFF,   1'b0, 0);
    run(16'd0,     16'd5,      16'd0,     16'd0,      1'b0, 0);
    run(16'h8000,  16'd3,      16'd10922, 16'd2,      1'b0, 2);
    run(16'd0,     16'd0,      16'hFFFF,  16'd0,      1'b1, 3);

    // Reset in the middle of an iteration must abort without a result.
    wait_ready();
    set_model(16'd50000, 16'd3);
    dividend = 16'd50000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("no stale result", 32'(out_valid), 32'd0);
    end
    run(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 0);

    // Model-only sweep over assorted operands.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] n, d;
      n = W'($urandom);
      d = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 65535));
      run(n, d, n / d, n % d, 1'b0, i % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
